// File: rtl/ct_f_spsram_arb_pkg.sv
// Shared types and constants for the 8192x128 single-port SRAM arbiter.
//   arb_state_e : controller state (INIT = zero-fill in progress, RUN = serving requests)
//   rid_t       : requester id (0 or 1)
//   SRAM_DEPTH  : number of words in the default-sized array
package ct_f_spsram_arb_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 13;
  localparam int unsigned DEF_DATA_WIDTH = 128;
  localparam int unsigned SRAM_DEPTH     = 2 ** DEF_ADDR_WIDTH;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } arb_state_e;

  typedef logic rid_t;

endpackage

// File: rtl/ct_f_rr_arb2.sv
// Two-way round-robin arbiter.
//   CLK, RST : clock, asynchronous active-high reset
//   req[1:0] : request vector
//   en       : arbitration enable; no grant is issued while low
//   gnt[1:0] : one-hot grant, combinational from req/en/rr_ptr
// rr_ptr names the requester that wins a tie; after a grant to requester i
// it moves to the other one.
module ct_f_rr_arb2
  import ct_f_spsram_arb_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  rid_t rr_ptr;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) begin
        gnt = rr_ptr ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_ptr <= 1'b0;
    end else if (gnt[0]) begin
      rr_ptr <= 1'b1;
    end else if (gnt[1]) begin
      rr_ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/ct_f_spsram_arb_8192x128.sv
// Controller for the 8192x128 single-port SRAM wrapper.
// Shares the single port between two requesters (round-robin), returns read
// data one cycle after the read is granted, and zero-fills the whole array
// after reset (INIT_EN=1) or on an init_req pulse before serving traffic.
//   CLK, RST              : clock, asynchronous active-high reset
//   init_req              : one-cycle re-initialisation request (ignored in INIT)
//   init_done             : high while in RUN (doubles as the FSM state flag)
//   reqN_vld/wr/addr/wdata: request from requester N; reqN_rdy = grant (comb. on vld)
//   rspN_vld/rdata        : read response one cycle after grant, no backpressure
//   sram_a/cen/d/gwen/wen : wrapper pins, combinational from state/counter/grant
//   sram_q                : wrapper read data
// Handshake: a request transfers in a cycle where reqN_vld & reqN_rdy. rdy is
// a combinational function of vld; vld must never be derived from rdy.
module ct_f_spsram_arb_8192x128
  import ct_f_spsram_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit          INIT_EN    = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  init_req,
  output logic                  init_done,
  input  logic                  req0_vld,
  input  logic                  req0_wr,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_rdy,
  output logic                  rsp0_vld,
  output logic [DATA_WIDTH-1:0] rsp0_rdata,
  input  logic                  req1_vld,
  input  logic                  req1_wr,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_rdy,
  output logic                  rsp1_vld,
  output logic [DATA_WIDTH-1:0] rsp1_rdata,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic [DATA_WIDTH-1:0] sram_d,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  arb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q, init_cnt_d;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] d_q;
  logic                  rsp_vld_q;
  rid_t                  rsp_id_q;

  logic [1:0]            gnt;
  logic                  gnt_any;
  rid_t                  g_id;
  logic                  g_wr;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_wdata;

  // Requests are only served in RUN; the init_req cycle itself still counts
  // as RUN, so a grant in that cycle is allowed.
  ct_f_rr_arb2 u_arb (
    .CLK (CLK),
    .RST (RST),
    .req ({req1_vld, req0_vld}),
    .en  ((state_q == ST_RUN) && !RST),
    .gnt (gnt)
  );

  assign gnt_any = |gnt;
  assign g_id    = gnt[1];
  assign g_wr    = g_id ? req1_wr    : req0_wr;
  assign g_addr  = g_id ? req1_addr  : req0_addr;
  assign g_wdata = g_id ? req1_wdata : req0_wdata;

  assign req0_rdy  = gnt[0];
  assign req1_rdy  = gnt[1];
  assign init_done = (state_q == ST_RUN);

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    case (state_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + ADDR_WIDTH'(1);
        if (init_cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (init_req) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  // Pin drive. While RST is held the pins show their idle/reset values even
  // though the state register already sits in INIT. With no access, a and d
  // hold the last driven value.
  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = a_q;
    sram_d    = d_q;
    if (!RST) begin
      if (state_q == ST_INIT) begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = init_cnt_q;
        sram_d    = '0;
      end else if (gnt_any) begin
        sram_cen = 1'b0;
        sram_a   = g_addr;
        if (g_wr) begin
          sram_gwen = 1'b0;
          sram_wen  = '0;
          sram_d    = g_wdata;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= INIT_EN ? ST_INIT : ST_RUN;
      init_cnt_q <= '0;
      a_q        <= '0;
      d_q        <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_id_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      a_q        <= sram_a;
      d_q        <= sram_d;
      rsp_vld_q  <= gnt_any && !g_wr;
      rsp_id_q   <= g_id;
    end
  end

  // The wrapper registers Q, so read data arrives with the registered id.
  assign rsp0_vld   = rsp_vld_q && (rsp_id_q == 1'b0);
  assign rsp1_vld   = rsp_vld_q && (rsp_id_q == 1'b1);
  assign rsp0_rdata = sram_q;
  assign rsp1_rdata = sram_q;

endmodule

// File: doc/ct_f_spsram_arb_8192x128.md
Name: ct_f_spsram_arb_8192x128

Overview:
Controller for the 8192x128 single-port SRAM wrapper (ct_f_spsram_8192x128). It shares the single port between two requesters using a round-robin policy. It returns read data one cycle after a read is accepted. After reset, or on request, it zero-initialises the whole array before it accepts any traffic. It sits between two L2-side clients and the SRAM macro wrapper, and drives the wrapper's A/CEN/D/GWEN/WEN pins directly.

Parameters:
ADDR_WIDTH, 13, SRAM word address width (depth = 2^ADDR_WIDTH)
DATA_WIDTH, 128, SRAM word width
INIT_EN, 1, 1 = zero-fill the array after reset; 0 = enter RUN directly after reset

Ports:
CLK  in  1  single clock, also drives the SRAM wrapper
RST  in  1  asynchronous, active-high reset
init_req  in  1  one-cycle pulse that requests a re-initialisation (zero-fill)
init_done  out  1  high while in RUN
req0_vld  in  1  requester 0 request valid
req0_wr  in  1  1 = write, 0 = read
req0_addr  in  ADDR_WIDTH  word address
req0_wdata  in  DATA_WIDTH  write data
req0_rdy  out  1  request accepted this cycle
rsp0_vld  out  1  read data valid (one-cycle pulse, no backpressure)
rsp0_rdata  out  DATA_WIDTH  read data
req1_vld, req1_wr, req1_addr, req1_wdata, req1_rdy, rsp1_vld, rsp1_rdata  same as requester 0
sram_a  out  ADDR_WIDTH  to wrapper A
sram_cen  out  1  to wrapper CEN (active low)
sram_d  out  DATA_WIDTH  to wrapper D
sram_gwen  out  1  to wrapper GWEN (active low)
sram_wen  out  DATA_WIDTH  to wrapper WEN (all-0 on write, all-1 otherwise)
sram_q  in  DATA_WIDTH  from wrapper Q

Behaviour:
- Reset values: state=INIT if INIT_EN else RUN; init_cnt=0; rr_ptr=0; init_done=0 (1 if INIT_EN=0); reqX_rdy=0; rspX_vld=0; sram_cen=1; sram_gwen=1; sram_wen=all-1; sram_a=0; sram_d=0.
- FSM states: INIT, RUN.
  - INIT: each cycle drive cen=0, gwen=0, wen=all-0, a=init_cnt, d=0. init_cnt increments each cycle.
  - INIT -> RUN: on the cycle init_cnt == 2^ADDR_WIDTH-1 is written. The fill takes exactly 8192 write cycles and init_done rises the following cycle.
  - RUN -> INIT: on init_req=1. init_cnt clears to 0 and the first fill write happens the next cycle. init_req is ignored while in INIT.
- Requesters are never granted in INIT; reqX_rdy=0 there. A request held across INIT is accepted once RUN is reached.
- RUN arbitration, combinational in the cycle:
  - Only one requester valid: it is granted.
  - Both valid: grant goes to rr_ptr.
  - After any grant to requester i, rr_ptr <= ~i.
  - reqX_rdy = grant X. rdy depends combinationally on vld; vld must not depend on rdy.
  - The same cycle as init_req=1 is treated as RUN: a grant is still allowed, and INIT starts the next cycle.
- SRAM drive on a grant: cen=0; a=granted addr.
  - Write: gwen=0, wen=all-0, d=wdata.
  - Read: gwen=1, wen=all-1.
  - No grant: cen=1, gwen=1, wen=all-1, a and d held.
  - All SRAM outputs are combinational from the state, counter and grant, with no extra register stage.
- Read latency is 1:
  - A read granted in cycle N gives rspX_vld=1 in N+1 for the granted requester only, with rspX_rdata=sram_q.
  - rsp_id and rsp_vld are registered; rdata is passed through from sram_q.
  - rspX_rdata is don't-care when rspX_vld=0 (driven from sram_q).
- Writes produce no response.
- Read-after-write to the same address in consecutive cycles returns the new data.
- A read granted the cycle before INIT starts still returns its response in the first INIT cycle.
- Asserting RST during INIT or RUN aborts immediately to reset values, and the fill restarts from 0.

Decomposition:
- Package ct_f_spsram_arb_pkg:
  - state enum (INIT, RUN)
  - requester-id typedef (1 bit)
  - constant SRAM_DEPTH = 2**ADDR_WIDTH
- Sub-module ct_f_rr_arb2: 2-way round-robin arbiter.
  - Inputs: CLK, RST, req[1:0], en.
  - Outputs: gnt[1:0] one-hot.
  - Owns rr_ptr.

Test Plan:
- Reset with INIT_EN=1 -> exactly 8192 cycles of cen=0/gwen=0/d=0 with a=0..8191 ascending; init_done=1 at cycle 8193; a read of addr 0x1ABC then returns 0.
- RUN, req0 writes 0xDEAD_BEEF to addr 5, then req0 reads addr 5 the next cycle -> rsp0_vld=1 one cycle after the read grant, rdata=0xDEAD_BEEF; rsp1_vld stays 0.
- Both requesters hold reads continuously from reset exit -> grants alternate 0,1,0,1; each rspX_vld occurs exactly 1 cycle after its own grant.
- req1 read pending during INIT -> req1_rdy=0 until init_done, then granted on the first RUN cycle.
- RUN, req0 read granted in the same cycle as init_req=1 -> rsp0_vld in the next cycle with the pre-fill data; afterwards a read of that address returns 0.
- RST asserted at init_cnt=100 and released -> fill restarts at a=0 and init_done is delayed a full 8192 cycles.
